// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_LANES completing functional units per
// cycle, packs winners into contiguous low lanes and registers the broadcast.
// Default grant order is round-robin from rr_ptr. Defining CDB_AGE_PRIORITY_EN
// switches to oldest-first by ROB age relative to rob_head.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 6,
    parameter int unsigned CDB_LANES = 3,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned XLEN      = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash_flag,
    input  logic [TAG_W-1:0]               rob_head,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
    input  logic [NUM_REQ*XLEN-1:0]        req_value,
    input  logic [NUM_REQ-1:0]             req_take_branch,
    input  logic [NUM_REQ*XLEN-1:0]        req_npc,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [CDB_LANES-1:0]           cdb_valid,
    output logic [CDB_LANES*TAG_W-1:0]     cdb_tag,
    output logic [CDB_LANES*XLEN-1:0]      cdb_value,
    output logic [CDB_LANES-1:0]           cdb_take_branch,
    output logic [CDB_LANES*XLEN-1:0]      cdb_npc,
    output logic [$clog2(NUM_REQ)-1:0]     rr_ptr
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(CDB_LANES + 1);

    // Raw selection before squash gating
    logic [NUM_REQ-1:0]   sel_grant;
    logic [CDB_LANES-1:0] sel_lane_vld;
    logic [PTR_W-1:0]     lane_idx [CDB_LANES];

    logic [CDB_LANES-1:0] lane_live;
    logic [PTR_W-1:0]     rr_ptr_d, rr_ptr_q;

    logic [CDB_LANES-1:0]       cdb_valid_q;
    logic [CDB_LANES*TAG_W-1:0] cdb_tag_d, cdb_tag_q;
    logic [CDB_LANES*XLEN-1:0]  cdb_value_d, cdb_value_q;
    logic [CDB_LANES-1:0]       cdb_take_branch_d, cdb_take_branch_q;
    logic [CDB_LANES*XLEN-1:0]  cdb_npc_d, cdb_npc_q;

`ifdef CDB_AGE_PRIORITY_EN

    logic [TAG_W-1:0] age [NUM_REQ];

    // ROB age of each requester; modular distance from the head
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age[i] = req_tag[i*TAG_W +: TAG_W] - rob_head;
        end
    end

    // Oldest-first selection, one lane per pass; strict < breaks ties to lower index
    always_comb begin : age_select
        logic [NUM_REQ-1:0] taken;
        logic               found;
        logic [TAG_W-1:0]   best_age;
        logic [PTR_W-1:0]   best;
        sel_grant    = '0;
        sel_lane_vld = '0;
        taken        = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            lane_idx[l] = '0;
        end
        for (int l = 0; l < CDB_LANES; l++) begin
            found    = 1'b0;
            best_age = '0;
            best     = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !taken[i] && (!found || age[i] < best_age)) begin
                    found    = 1'b1;
                    best_age = age[i];
                    best     = PTR_W'(i);
                end
            end
            if (found) begin
                taken[best]     = 1'b1;
                sel_grant[best] = 1'b1;
                sel_lane_vld[l] = 1'b1;
                lane_idx[l]     = best;
            end
        end
    end

    // Pointer is unused in age mode
    always_comb begin
        rr_ptr_d = '0;
    end

`else

    logic unused_rob_head;
    assign unused_rob_head = ^rob_head;

    // Round-robin scan from rr_ptr, wrapping, taking the first CDB_LANES valid requesters
    always_comb begin : rr_select
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] last;
        logic [CNT_W-1:0] cnt;
        sel_grant    = '0;
        sel_lane_vld = '0;
        last         = '0;
        cnt          = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            lane_idx[l] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req_valid[idx] && cnt < CNT_W'(CDB_LANES)) begin
                sel_grant[idx]    = 1'b1;
                sel_lane_vld[cnt] = 1'b1;
                lane_idx[cnt]     = idx;
                last              = idx;
                cnt               = cnt + CNT_W'(1);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (|sel_grant && !squash_flag) begin
            rr_ptr_d = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
        end
    end

`endif

    // Squash and reset suppress all grants in the same cycle
    always_comb begin
        req_ready = (reset || squash_flag) ? '0 : sel_grant;
        lane_live = squash_flag ? '0 : sel_lane_vld;
    end

    // Lane data mux; idle lanes broadcast zeros
    always_comb begin
        cdb_tag_d         = '0;
        cdb_value_d       = '0;
        cdb_take_branch_d = '0;
        cdb_npc_d         = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lane_live[l] && lane_idx[l] == PTR_W'(i)) begin
                    cdb_tag_d[l*TAG_W +: TAG_W]  = req_tag[i*TAG_W +: TAG_W];
                    cdb_value_d[l*XLEN +: XLEN]  = req_value[i*XLEN +: XLEN];
                    cdb_take_branch_d[l]         = req_take_branch[i];
                    cdb_npc_d[l*XLEN +: XLEN]    = req_npc[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Broadcast register and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid_q       <= '0;
            cdb_tag_q         <= '0;
            cdb_value_q       <= '0;
            cdb_take_branch_q <= '0;
            cdb_npc_q         <= '0;
            rr_ptr_q          <= '0;
        end else begin
            cdb_valid_q       <= lane_live;
            cdb_tag_q         <= cdb_tag_d;
            cdb_value_q       <= cdb_value_d;
            cdb_take_branch_q <= cdb_take_branch_d;
            cdb_npc_q         <= cdb_npc_d;
            rr_ptr_q          <= rr_ptr_d;
        end
    end

    assign cdb_valid       = cdb_valid_q;
    assign cdb_tag         = cdb_tag_q;
    assign cdb_value       = cdb_value_q;
    assign cdb_take_branch = cdb_take_branch_q;
    assign cdb_npc         = cdb_npc_q;
    assign rr_ptr          = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter. Builds with or without CDB_AGE_PRIORITY_EN.
module tb_cdb_arbiter;

    logic           clock = 1'b0;
    logic           reset;
    logic           squash_flag;
    logic [4:0]     rob_head;
    logic [5:0]     req_valid;
    logic [29:0]    req_tag;
    logic [191:0]   req_value;
    logic [5:0]     req_take_branch;
    logic [191:0]   req_npc;
    logic [5:0]     req_ready;
    logic [2:0]     cdb_valid;
    logic [14:0]    cdb_tag;
    logic [95:0]    cdb_value;
    logic [2:0]     cdb_take_branch;
    logic [95:0]    cdb_npc;
    logic [2:0]     rr_ptr;

    cdb_arbiter #(
        .NUM_REQ   (6),
        .CDB_LANES (3),
        .TAG_W     (5),
        .XLEN      (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .squash_flag     (squash_flag),
        .rob_head        (rob_head),
        .req_valid       (req_valid),
        .req_tag         (req_tag),
        .req_value       (req_value),
        .req_take_branch (req_take_branch),
        .req_npc         (req_npc),
        .req_ready       (req_ready),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_take_branch (cdb_take_branch),
        .cdb_npc         (cdb_npc),
        .rr_ptr          (rr_ptr)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  v;
        logic [14:0] tag;
        logic [95:0] val;
        logic [2:0]  tb;
        logic [95:0] npc;
        logic [2:0]  rr;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [4:0]  m_tag [6];
    logic [31:0] m_val [6];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] t, input logic [31:0] v);
        m_tag[i] = t;
        m_val[i] = v;
        req_tag[i*5 +: 5]    = t;
        req_value[i*32 +: 32] = v;
        req_take_branch[i]   = t[0];
        req_npc[i*32 +: 32]  = 32'h4000_0000 | {25'd0, t, 2'b00};
    endtask

    task automatic start_exp(input string name, input logic [2:0] rr);
        cur.name = name;
        cur.v    = '0;
        cur.tag  = '0;
        cur.val  = '0;
        cur.tb   = '0;
        cur.npc  = '0;
        cur.rr   = rr;
    endtask

    // Expect requester i on lane l
    task automatic lane(input int l, input int i);
        cur.v[l]            = 1'b1;
        cur.tag[l*5 +: 5]   = m_tag[i];
        cur.val[l*32 +: 32] = m_val[i];
        cur.tb[l]           = m_tag[i][0];
        cur.npc[l*32 +: 32] = 32'h4000_0000 | {25'd0, m_tag[i], 2'b00};
    endtask

    task automatic push_exp();
        sb.push_back(cur);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.name, "_valid"}, 128'(cdb_valid), 128'(e.v));
            chk({e.name, "_tag"}, 128'(cdb_tag), 128'(e.tag));
            chk({e.name, "_value"}, 128'(cdb_value), 128'(e.val));
            chk({e.name, "_tb"}, 128'(cdb_take_branch), 128'(e.tb));
            chk({e.name, "_npc"}, 128'(cdb_npc), 128'(e.npc));
            chk({e.name, "_rr"}, 128'(rr_ptr), 128'(e.rr));
            for (int a = 0; a < 3; a++) begin
                for (int b = a + 1; b < 3; b++) begin
                    if (cdb_valid[a] && cdb_valid[b]) begin
                        chk({e.name, "_dup_tag"},
                            128'(cdb_tag[a*5 +: 5] == cdb_tag[b*5 +: 5]), 128'(0));
                    end
                end
            end
        end
    endtask

    task automatic check_ready(input string name, input logic [5:0] exp);
        #1;
        chk({name, "_ready"}, 128'(req_ready), 128'(exp));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        compare_out();
    endtask

    initial begin
        reset           = 1'b1;
        squash_flag     = 1'b0;
        rob_head        = 5'd30;
        req_valid       = 6'b111111;
        req_tag         = '0;
        req_value       = '0;
        req_take_branch = '0;
        req_npc         = '0;
        for (int i = 0; i < 6; i++) set_req(i, 5'(i), 32'd0);

        // Reset state, ready held low despite valid requests
        #2;
        chk("reset_ready", 128'(req_ready), 128'(0));
        start_exp("reset", 3'd0); push_exp(); compare_out();
        #10;
        reset     = 1'b0;
        req_valid = '0;

`ifdef CDB_AGE_PRIORITY_EN
        // Oldest-first: ages 4,1,0,7 from head 30
        set_req(0, 5'd2, 32'hA); set_req(1, 5'd31, 32'hB);
        set_req(2, 5'd30, 32'hC); set_req(3, 5'd5, 32'hD);
        req_valid = 6'b001111;
        check_ready("age1", 6'b000111);
        start_exp("age1", 3'd0); lane(0, 2); lane(1, 1); lane(2, 0); push_exp();
        tick();

        req_valid = 6'b001000;
        check_ready("age2", 6'b001000);
        start_exp("age2", 3'd0); lane(0, 3); push_exp();
        tick();

        set_req(0, 5'd7, 32'h70); set_req(1, 5'd3, 32'h30);
        req_valid = 6'b000011;
        check_ready("age3", 6'b000011);
        start_exp("age3", 3'd0); lane(0, 1); lane(1, 0); push_exp();
        tick();

        squash_flag = 1'b1;
        check_ready("squash", 6'b000000);
        start_exp("squash", 3'd0); push_exp();
        tick();
        squash_flag = 1'b0;

        for (int i = 0; i < 6; i++) set_req(i, 5'(i * 5), 32'(i + 100));
        req_valid = 6'b111111;
        check_ready("age_full", 6'b000111);
        start_exp("age_full", 3'd0); lane(0, 0); lane(1, 1); lane(2, 2); push_exp();
        tick();
`else
        // First grant after reset
        set_req(0, 5'd4, 32'hA); set_req(1, 5'd5, 32'hB); set_req(2, 5'd6, 32'hC);
        req_valid = 6'b000111;
        check_ready("rr1", 6'b000111);
        start_exp("rr1", 3'd3); lane(0, 0); lane(1, 1); lane(2, 2); push_exp();
        tick();

        // All valid, two cycles from rr_ptr=3
        for (int i = 0; i < 6; i++) set_req(i, 5'(8 + i), 32'(16'hB00 + i));
        req_valid = 6'b111111;
        check_ready("all_a", 6'b111000);
        start_exp("all_a", 3'd0); lane(0, 3); lane(1, 4); lane(2, 5); push_exp();
        tick();
        check_ready("all_b", 6'b000111);
        start_exp("all_b", 3'd3); lane(0, 0); lane(1, 1); lane(2, 2); push_exp();
        tick();

        // Wrap: req5 then req0
        set_req(5, 5'd20, 32'h5555); set_req(0, 5'd21, 32'h0000_0F0F);
        req_valid = 6'b100001;
        check_ready("wrap", 6'b100001);
        start_exp("wrap", 3'd1); lane(0, 5); lane(1, 0); push_exp();
        tick();

        // Idle cycle holds pointer
        req_valid = 6'b000000;
        check_ready("idle", 6'b000000);
        start_exp("idle", 3'd1); push_exp();
        tick();

        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22);
        req_valid = 6'b000011;
        check_ready("pre_sq", 6'b000011);
        start_exp("pre_sq", 3'd1); lane(0, 1); lane(1, 0); push_exp();
        tick();

        // Squash kills grants and next broadcast; pointer holds
        squash_flag = 1'b1;
        check_ready("squash", 6'b000000);
        start_exp("squash", 3'd1); push_exp();
        tick();
        squash_flag = 1'b0;

        set_req(2, 5'd3, 32'h33);
        req_valid = 6'b000110;
        check_ready("post_sq", 6'b000110);
        start_exp("post_sq", 3'd3); lane(0, 1); lane(1, 2); push_exp();
        tick();

        set_req(4, 5'd9, 32'h99);
        req_valid = 6'b010000;
        check_ready("single", 6'b010000);
        start_exp("single", 3'd5); lane(0, 4); push_exp();
        tick();

        for (int i = 0; i < 6; i++) set_req(i, 5'(10 + i), 32'(16'hC00 + i));
        req_valid = 6'b111111;
        check_ready("rr_full", 6'b100011);
        start_exp("rr_full", 3'd2); lane(0, 5); lane(1, 0); lane(2, 1); push_exp();
        tick();
`endif

        // Async reset mid-cycle while all lanes are valid
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ready", 128'(req_ready), 128'(0));
        start_exp("async_rst", 3'd0); push_exp(); compare_out();
        #2;
        reset = 1'b0;

        set_req(0, 5'd17, 32'h1717);
        req_valid = 6'b000001;
        check_ready("after_rst", 6'b000001);
`ifdef CDB_AGE_PRIORITY_EN
        start_exp("after_rst", 3'd0);
`else
        start_exp("after_rst", 3'd1);
`endif
        lane(0, 0); push_exp();
        tick();

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completing functional units onto the 3-lane common data bus that feeds ROB completion (CDB_ROB_PACKET[2:0]) and RS/MT wakeup.
- Grants up to CDB_LANES requesters per cycle and packs the winners into contiguous low lanes. The ROB stops scanning at the first invalid lane, so packing is mandatory.
- Registers the bus: a granted result appears on the CDB one cycle after grant.
- A squash flushes the in-flight registered broadcast.

Parameters:
- NUM_REQ, 6, number of functional-unit requesters.
- CDB_LANES, 3, CDB width; must match the ROB completion port count.
- TAG_W, 5, ROB tag width ($clog2(`ROBLEN)).
- XLEN, 32, value and NPC width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- squash_flag  in  1  pipeline flush (synchronous).
- rob_head  in  TAG_W  current ROB head index; used only by the optional feature.
- req_valid  in  NUM_REQ  requester i has a completed result.
- req_tag  in  NUM_REQ*TAG_W  ROB tag per requester.
- req_value  in  NUM_REQ*XLEN  result value per requester.
- req_take_branch  in  NUM_REQ  resolved branch-taken bit per requester.
- req_npc  in  NUM_REQ*XLEN  resolved next PC per requester.
- req_ready  out  NUM_REQ  grant; combinational from req_valid and arbiter state.
- cdb_valid  out  CDB_LANES  lane valid, registered.
- cdb_tag  out  CDB_LANES*TAG_W  lane tag, registered.
- cdb_value  out  CDB_LANES*XLEN  lane value, registered.
- cdb_take_branch  out  CDB_LANES  lane branch-taken bit, registered.
- cdb_npc  out  CDB_LANES*XLEN  lane NPC, registered.
- rr_ptr  out  $clog2(NUM_REQ)  round-robin start pointer (debug/verification).

Behaviour:
- Reset (async):
  - cdb_valid=0; cdb_tag/value/take_branch/npc=0.
  - rr_ptr=0; req_ready=0 while reset is high.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] at a rising edge.
  - A requester holds valid and data stable until granted.
  - req_ready never depends on req_tag or req_value except under the optional feature.
- Grant selection (default round-robin):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - Grant the first min(CDB_LANES, popcount(req_valid)) valid requesters found.
- Lane packing:
  - The k-th granted requester in scan order drives lane k.
  - Valid lanes are always 0..n-1 and never sparse; the remaining lanes have cdb_valid=0 with data 0.
- Latency: data granted in cycle t is on cdb_* during cycle t+1. cdb_* is updated every cycle; there is no hold.
- Pointer update:
  - If any grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If there are no grants, rr_ptr holds.
- Fairness: with CDB_LANES < NUM_REQ, a continuously valid requester is granted within ceil(NUM_REQ/CDB_LANES) cycles.
- Squash:
  - When squash_flag=1, req_ready=0 in the same cycle and no grants occur.
  - Next cycle cdb_valid=0 on all lanes.
  - rr_ptr holds. Requesters are expected to drop valid; any still-valid request is arbitrated normally after the flag deasserts.
- Reset mid-operation: all registered broadcast content is lost immediately (async); no partial lane output.
- Tag uniqueness: the block does not check for duplicate tags. The bench asserts that no two valid lanes carry the same tag.
- No backpressure from the CDB; the bus is always accepted.

Optional Feature:
- Macro: CDB_AGE_PRIORITY_EN.
- Defined:
  - Grant order is oldest-first by ROB age = (req_tag - rob_head) mod 2^TAG_W, smallest first.
  - Ties (equal age, illegal in practice) break by lower index.
  - Lanes are packed in age order, so lane 0 is the oldest.
  - rr_ptr holds at 0 and is unused.
- Undefined: round-robin as above; rob_head is ignored.

Test Plan:
- After reset, req_valid=6'b000111, tags 4,5,6, values 0xA,0xB,0xC -> req_ready=000111. Next cycle cdb_valid=111, lanes carry tags 4,5,6. rr_ptr=3.
- req_valid=6'b111111 held constant, rr_ptr=0 -> cycle 1 grants 0,1,2 (rr_ptr=3); cycle 2 grants 3,4,5 (rr_ptr=0).
- req_valid=6'b100001, rr_ptr=3 -> grants 5 then 0 (wrap). Lane0=req5, lane1=req0, lane2 invalid. rr_ptr=1.
- Squash: req_valid=6'b000011 with squash_flag=1 -> req_ready=0; next cycle cdb_valid=000 even though the previous cycle granted 2 lanes.
- Async reset asserted mid-cycle while cdb_valid=111 -> cdb_valid=000 and rr_ptr=0 immediately, without waiting for a clock edge.
- CDB_AGE_PRIORITY_EN: rob_head=30, requesters 0..3 with tags 2,31,30,5 -> grants 2,1,0 (ages 0,1,4). Lane0 tag 30, lane1 tag 31, lane2 tag 2. Req3 waits.
